// File: rtl/cam_lookup_arb.sv
// Lookup controller in front of an 8-entry CAM: table-load sequencing, two-way round-robin
// arbitration and a valid/ready response channel. Define CAM_LOOKUP_ARB_STATS_EN for hit/miss counters.
module cam_lookup_arb #(
    parameter int         DATA_W      = 16,
    parameter int         ADDR_W      = 3,
    parameter int         CNT_W       = 4,
    parameter int         CAM_LAT     = 1,
    parameter logic [1:0] INIT_CODE   = 2'b11,
    parameter int         INIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_key,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_key,
    output logic              req1_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic              rsp_hit,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [CNT_W-1:0]  rsp_count,
    output logic [DATA_W-1:0] cam_data_lookup,
    output logic [1:0]        cam_init,
    input  logic [ADDR_W-1:0] cam_addr,
    input  logic              cam_valid,
    input  logic [CNT_W-1:0]  cam_num_match,
    output logic              busy
`ifdef CAM_LOOKUP_ARB_STATS_EN
    ,
    output logic [15:0]       stat_hits,
    output logic [15:0]       stat_miss
`endif
);

    localparam int NUM_REQ = 2;
    localparam int LAT_W   = 3;
    localparam int INIT_W  = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]        state_reg, state_next;
    logic [INIT_W-1:0] init_cnt_reg, init_cnt_next;
    logic [LAT_W-1:0]  lat_cnt_reg, lat_cnt_next;
    logic              ptr_reg, ptr_next;
    logic [DATA_W-1:0] key_reg, key_next;
    logic              id_reg, id_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic              rsp_hit_reg, rsp_hit_next;
    logic [ADDR_W-1:0] rsp_addr_reg, rsp_addr_next;
    logic [CNT_W-1:0]  rsp_count_reg, rsp_count_next;

    logic [NUM_REQ-1:0] req_valid_vec;
    logic [NUM_REQ-1:0] req_ready_vec;
    logic [DATA_W-1:0]  req_key_arr [NUM_REQ];
    logic               grant_en;
    logic               grant_id;

    assign req_valid_vec  = {req1_valid, req0_valid};
    assign req_key_arr[0] = req0_key;
    assign req_key_arr[1] = req1_key;

    // The pointer only matters on contention; a lone requester wins outright.
    assign grant_en = (state_reg == ST_IDLE) && (|req_valid_vec);
    assign grant_id = (&req_valid_vec) ? ptr_reg : req_valid_vec[1];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready_vec[gi] = grant_en && (int'(grant_id) == gi);
        end
    endgenerate

    assign req0_ready = req_ready_vec[0];
    assign req1_ready = req_ready_vec[1];

    always_comb begin
        state_next     = state_reg;
        init_cnt_next  = init_cnt_reg;
        lat_cnt_next   = lat_cnt_reg;
        ptr_next       = ptr_reg;
        key_next       = key_reg;
        id_next        = id_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_hit_next   = rsp_hit_reg;
        rsp_addr_next  = rsp_addr_reg;
        rsp_count_next = rsp_count_reg;

        case (state_reg)
            ST_INIT: begin
                if (init_cnt_reg == INIT_LAST) begin
                    init_cnt_next = '0;
                    state_next    = ST_IDLE;
                end else begin
                    init_cnt_next = init_cnt_reg + INIT_W'(1);
                end
            end
            ST_IDLE: begin
                if (grant_en) begin
                    key_next     = req_key_arr[grant_id];
                    id_next      = grant_id;
                    lat_cnt_next = LAT_W'(CAM_LAT);
                    ptr_next     = ~grant_id;
                    state_next   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Count 1 marks the cycle in which the CAM result is valid.
                if (lat_cnt_reg == LAT_W'(1)) begin
                    rsp_hit_next   = cam_valid;
                    rsp_addr_next  = cam_addr;
                    rsp_count_next = cam_num_match;
                    rsp_valid_next = 1'b1;
                    state_next     = ST_RESP;
                end else begin
                    lat_cnt_next = lat_cnt_reg - LAT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = ST_IDLE;
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_INIT;
            init_cnt_reg  <= '0;
            lat_cnt_reg   <= '0;
            ptr_reg       <= 1'b0;
            key_reg       <= '0;
            id_reg        <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_hit_reg   <= 1'b0;
            rsp_addr_reg  <= '0;
            rsp_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            init_cnt_reg  <= init_cnt_next;
            lat_cnt_reg   <= lat_cnt_next;
            ptr_reg       <= ptr_next;
            key_reg       <= key_next;
            id_reg        <= id_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_hit_reg   <= rsp_hit_next;
            rsp_addr_reg  <= rsp_addr_next;
            rsp_count_reg <= rsp_count_next;
        end
    end

    assign cam_init        = (state_reg == ST_INIT) ? INIT_CODE : 2'b00;
    assign busy            = (state_reg != ST_IDLE);
    assign cam_data_lookup = key_reg;
    assign rsp_valid       = rsp_valid_reg;
    assign rsp_id          = id_reg;
    assign rsp_hit         = rsp_hit_reg;
    assign rsp_addr        = rsp_addr_reg;
    assign rsp_count       = rsp_count_reg;

`ifdef CAM_LOOKUP_ARB_STATS_EN
    logic [15:0] stat_hits_reg;
    logic [15:0] stat_miss_reg;
    logic        rsp_fire;

    assign rsp_fire = rsp_valid_reg && rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_hits_reg <= '0;
            stat_miss_reg <= '0;
        end else if (rsp_fire) begin
            if (rsp_hit_reg) begin
                if (stat_hits_reg != 16'hFFFF) stat_hits_reg <= stat_hits_reg + 16'd1;
            end else begin
                if (stat_miss_reg != 16'hFFFF) stat_miss_reg <= stat_miss_reg + 16'd1;
            end
        end
    end

    assign stat_hits = stat_hits_reg;
    assign stat_miss = stat_miss_reg;
`endif

endmodule

// File: tb/tb_cam_lookup_arb.sv
// Bench for cam_lookup_arb: directed steps plus randomized traffic, with a table-driven CAM
// and a request/arbitration reference model. Honors CAM_LOOKUP_ARB_STATS_EN.
module tb_cam_lookup_arb;

    localparam int CAM_LAT     = 1;
    localparam int INIT_CYCLES = 2;
    localparam logic [15:0] CAM_TABLE [8] = '{16'h1111, 16'h00F0, 16'h2222, 16'h0003,
                                              16'h0004, 16'h2222, 16'h2222, 16'h5555};

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_key, req1_key;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_hit;
    logic [2:0]  rsp_addr;
    logic [3:0]  rsp_count;
    logic [15:0] cam_data_lookup;
    logic [1:0]  cam_init;
    logic [2:0]  cam_addr;
    logic        cam_valid;
    logic [3:0]  cam_num_match;
    logic        busy;
    logic [7:0]  cam_bus;
`ifdef CAM_LOOKUP_ARB_STATS_EN
    logic [15:0] stat_hits, stat_miss;
    int          hits_m, miss_m;
`endif

    int          total = 0;
    int          bad = 0;
    int          txn_no = 0;
    bit          want0, want1;
    logic [15:0] key0, key1;
    int          last_granted;
    logic        obs_id, obs_hit;
    logic [2:0]  obs_addr;
    logic [3:0]  obs_count;

    always #5 clk = ~clk;

    cam_lookup_arb #(.CAM_LAT(CAM_LAT), .INIT_CYCLES(INIT_CYCLES)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_key(req0_key), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_key(req1_key), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_hit(rsp_hit), .rsp_addr(rsp_addr), .rsp_count(rsp_count),
        .cam_data_lookup(cam_data_lookup), .cam_init(cam_init),
        .cam_addr(cam_addr), .cam_valid(cam_valid), .cam_num_match(cam_num_match),
        .busy(busy)
`ifdef CAM_LOOKUP_ARB_STATS_EN
        , .stat_hits(stat_hits), .stat_miss(stat_miss)
`endif
    );

    // CAM model: {hit, lowest matching address, number of matches}
    function automatic logic [7:0] cam_ref(input logic [15:0] k);
        logic       hit;
        logic [2:0] a;
        logic [3:0] c;
        hit = 1'b0;
        a   = 3'd0;
        c   = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (CAM_TABLE[i] == k) begin
                hit = 1'b1;
                a   = 3'(i);
                c   = c + 4'd1;
            end
        end
        return {hit, a, c};
    endfunction

    always_comb cam_bus = cam_ref(cam_data_lookup);
    assign cam_valid     = cam_bus[7];
    assign cam_addr      = cam_bus[6:4];
    assign cam_num_match = cam_bus[3:0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic drive_reqs();
        req0_valid = want0;
        req0_key   = key0;
        req1_valid = want1;
        req1_key   = key1;
    endtask

    function automatic logic [15:0] pick_key();
        logic [15:0] k;
        if ($urandom_range(0, 3) == 0) k = 16'($urandom);
        else k = CAM_TABLE[$urandom_range(0, 7)];
        return k;
    endfunction

    task automatic do_reset_init();
        int n;
        reset     = 1'b1;
        rsp_ready = 1'b0;
        drive_reqs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_cam_init", 32'(cam_init), 32'h3);
        check("rst_busy", 32'(busy), 1);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_fields", {23'd0, rsp_id, rsp_hit, rsp_addr, rsp_count}, 0);
        check("rst_key", 32'(cam_data_lookup), 0);
        reset = 1'b0;
        n = 0;
        while (cam_init === 2'b11 && n < 20) begin
            check("init_ready", 32'({req1_ready, req0_ready}), 0);
            check("init_busy", 32'(busy), 1);
            @(negedge clk);
            #1;
            n++;
        end
        check("init_cycles", 32'(n), 32'(INIT_CYCLES));
        check("idle_cam_init", 32'(cam_init), 0);
        check("idle_busy", 32'(busy), 0);
        last_granted = 1;
`ifdef CAM_LOOKUP_ARB_STATS_EN
        hits_m = 0;
        miss_m = 0;
`endif
    endtask

    task automatic serve_one(input int bp);
        int          n;
        int          exp_id;
        logic [15:0] k;
        logic [7:0]  exp;
        drive_reqs();
        rsp_ready = (bp == 0);
        #1;
        n = 0;
        while (!(req0_ready || req1_ready) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("grant_seen", 32'(req0_ready | req1_ready), 1);
        if (!(req0_ready || req1_ready)) return;
        exp_id = (want0 && want1) ? (1 - last_granted) : (want1 ? 1 : 0);
        check("one_ready", 32'(req0_ready & req1_ready), 0);
        check("grant_id", 32'(req1_ready), 32'(exp_id));
        k            = (exp_id == 1) ? key1 : key0;
        exp          = cam_ref(k);
        last_granted = exp_id;
        @(negedge clk);
        if (exp_id == 1) want1 = 1'b0;
        else want0 = 1'b0;
        drive_reqs();
        #1;
        n = 1;
        while (rsp_valid !== 1'b1 && n < 20) begin
            check("wait_key", 32'(cam_data_lookup), 32'(k));
            check("wait_ready", 32'({req1_ready, req0_ready}), 0);
            check("wait_busy", 32'(busy), 1);
            @(negedge clk);
            #1;
            n++;
        end
        check("latency", 32'(n), 32'(CAM_LAT + 1));
        check("rsp_id", 32'(rsp_id), 32'(exp_id));
        check("rsp_hit", 32'(rsp_hit), 32'(exp[7]));
        check("rsp_addr", 32'(rsp_addr), 32'(exp[6:4]));
        check("rsp_count", 32'(rsp_count), 32'(exp[3:0]));
        check("rsp_ready_block", 32'({req1_ready, req0_ready}), 0);
        obs_id    = rsp_id;
        obs_hit   = rsp_hit;
        obs_addr  = rsp_addr;
        obs_count = rsp_count;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            #1;
            check("hold_valid", 32'(rsp_valid), 1);
            check("hold_fields", {23'd0, rsp_id, rsp_hit, rsp_addr, rsp_count},
                  {23'd0, 1'(exp_id), exp});
            check("hold_ready", 32'({req1_ready, req0_ready}), 0);
            check("hold_busy", 32'(busy), 1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("post_valid", 32'(rsp_valid), 0);
        check("post_busy", 32'(busy), 0);
`ifdef CAM_LOOKUP_ARB_STATS_EN
        if (exp[7]) hits_m = (hits_m < 65535) ? hits_m + 1 : hits_m;
        else miss_m = (miss_m < 65535) ? miss_m + 1 : miss_m;
        check("stat_hits", 32'(stat_hits), 32'(hits_m));
        check("stat_miss", 32'(stat_miss), 32'(miss_m));
`endif
        rsp_ready = 1'b0;
        txn_no++;
        $display("txn %0d: id=%0d key=%h hit=%0d addr=%0d count=%0d bp=%0d",
                 txn_no, exp_id, k, exp[7], exp[6:4], exp[3:0], bp);
    endtask

    initial begin
        int n;
        int bp;
        reset     = 1'b1;
        rsp_ready = 1'b0;
        want0 = 1'b1; key0 = 16'h0003;
        want1 = 1'b0; key1 = 16'h0000;
        last_granted = 1;

        // Init sequence with requester 0 already waiting
        do_reset_init();

        // Single hit request from requester 0
        serve_one(0);
        check("single_id", 32'(obs_id), 0);
        check("single_hit", 32'(obs_hit), 1);
        check("single_addr", 32'(obs_addr), 3);
        check("single_count", 32'(obs_count), 1);

        // Miss from requester 1
        want1 = 1'b1; key1 = 16'h0000;
        serve_one(0);
        check("miss_id", 32'(obs_id), 1);
        check("miss_hit", 32'(obs_hit), 0);
        check("miss_count", 32'(obs_count), 0);

        // Continuous contention: grants alternate starting with requester 0
        want0 = 1'b1; key0 = 16'h0004;
        want1 = 1'b1; key1 = 16'h00F0;
        for (int i = 0; i < 4; i++) begin
            serve_one(0);
            check("contend_id", 32'(obs_id), 32'(i % 2));
            want0 = 1'b1;
            want1 = 1'b1;
        end

        // Backpressure with the other requester still pending
        serve_one(5);

        // Randomized traffic
        for (int t = 0; t < 24; t++) begin
            if (!want0 && $urandom_range(0, 1) == 1) begin want0 = 1'b1; key0 = pick_key(); end
            if (!want1 && $urandom_range(0, 1) == 1) begin want1 = 1'b1; key1 = pick_key(); end
            if (!want0 && !want1) begin want0 = 1'b1; key0 = pick_key(); end
            bp = int'($urandom_range(0, 3));
            serve_one(bp);
        end

        // Reset while a lookup is in flight
        want0 = 1'b1; key0 = 16'h2222;
        want1 = 1'b1; key1 = 16'h1111;
        drive_reqs();
        #1;
        n = 0;
        while (!(req0_ready || req1_ready) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("mid_grant_seen", 32'(req0_ready | req1_ready), 1);
        check("mid_grant_id", 32'(req1_ready), 32'(1 - last_granted));
        @(negedge clk);
        #1;
        check("mid_wait_busy", 32'(busy), 1);
        check("mid_wait_valid", 32'(rsp_valid), 0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 0);
        check("mid_rst_cam_init", 32'(cam_init), 32'h3);
        check("mid_rst_busy", 32'(busy), 1);
        check("mid_rst_ready", 32'({req1_ready, req0_ready}), 0);
        do_reset_init();
        serve_one(0);
        check("post_rst_ptr", 32'(obs_id), 0);
        serve_one(1);
        check("post_rst_second", 32'(obs_id), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cam_lookup_arb.md
Name: cam_lookup_arb

Overview:
- Controller placed in front of the 8-entry, 16-bit CAM (ports data_lookup, init, addr, valid, num_match).
- Runs the CAM table-load sequence after reset.
- Round-robin arbitrates lookup requests from two requesters.
- Drives the CAM key, waits the CAM latency, then returns the registered result through a valid/ready response channel tagged with the requester ID.

Parameters:
- DATA_W, 16, lookup key width (matches CAM data_lookup).
- ADDR_W, 3, CAM match-address width.
- CNT_W, 4, CAM num_match width.
- CAM_LAT, 1, cycles from key presented to CAM result valid (1..4).
- INIT_CODE, 2'b11, value driven on cam_init during the table-load phase.
- INIT_CYCLES, 2, number of cycles INIT_CODE is held.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 lookup request.
- req0_key  in  DATA_W  requester 0 key.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req1_valid  in  1  requester 1 lookup request.
- req1_key  in  DATA_W  requester 1 key.
- req1_ready  out  1  requester 1 request accepted this cycle.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that owns the response.
- rsp_hit  out  1  CAM valid (at least one match).
- rsp_addr  out  ADDR_W  CAM match address.
- rsp_count  out  CNT_W  CAM num_match.
- cam_data_lookup  out  DATA_W  key to CAM.
- cam_init  out  2  init control to CAM.
- cam_addr  in  ADDR_W  CAM result address.
- cam_valid  in  1  CAM result hit flag.
- cam_num_match  in  CNT_W  CAM match count.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: synchronous, active-high; all state and outputs clear on the next clk edge regardless of state.
- Reset values: state=INIT, cam_init=INIT_CODE, cam_data_lookup=0, req*_ready=0, rsp_valid=0, rsp_id=0, rsp_hit=0, rsp_addr=0, rsp_count=0, busy=1, round-robin pointer=0 (requester 0 has priority).
- FSM states: INIT, IDLE, WAIT, RESP.
- INIT:
  - cam_init=INIT_CODE for INIT_CYCLES cycles, counted from the first cycle after reset deasserts.
  - Then cam_init=2'b00 and state goes to IDLE.
  - cam_init stays 2'b00 in every other state.
- IDLE:
  - If any reqN_valid is high, grant one requester and assert its reqN_ready combinationally in that cycle.
  - Only one ready is ever asserted at a time.
  - On a grant, register the key into cam_data_lookup and the ID, load the latency counter with CAM_LAT, then go to WAIT.
- Arbitration:
  - When both requests are valid, grant the requester the pointer selects.
  - After each grant, the pointer moves to the other requester.
  - When only one request is valid, grant it regardless of the pointer; the pointer still toggles away from the granted requester.
- WAIT:
  - cam_data_lookup is held stable.
  - Decrement the counter each cycle.
  - When the counter reaches 1, sample cam_valid, cam_addr and cam_num_match into rsp_hit, rsp_addr and rsp_count, set rsp_valid=1 and go to RESP.
  - Total latency from the grant cycle to rsp_valid is CAM_LAT+1 cycles.
- RESP:
  - rsp_* outputs are held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid&&rsp_ready, clear rsp_valid and go to IDLE.
  - No new grant is given in the same cycle, so there is at most one outstanding lookup.
- Requests in INIT, WAIT and RESP see ready=0; requesters must hold valid and key until they get ready.
- A miss (cam_valid=0) still returns a response with rsp_hit=0; rsp_addr and rsp_count are passed through unmodified.

Optional Feature:
- Macro: CAM_LOOKUP_ARB_STATS_EN.
- When defined:
  - Adds outputs stat_hits[15:0] and stat_miss[15:0].
  - The matching counter increments on each response handshake (rsp_valid&&rsp_ready), according to rsp_hit.
  - Counters saturate at 16'hFFFF and clear on reset.
- When undefined: these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Init: reset=1 for 2 cycles, then release -> cam_init=2'b11 for exactly 2 cycles, then 2'b00; busy drops to 0 in IDLE; no ready is asserted during INIT.
- Single request: req0_valid=1, key=16'h0003, CAM returns valid=1, addr=3'd3, num_match=4'd1, rsp_ready=1 -> cam_data_lookup=16'h0003, rsp_valid exactly 2 cycles after grant (CAM_LAT=1), rsp_id=0, rsp_hit=1, rsp_addr=3, rsp_count=1.
- Contention: both requests valid continuously, keys 16'h0004 and 16'h00F0 -> grants alternate 0,1,0,1; rsp_id matches; each requester sees ready once per two transactions.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, req*_ready=0 throughout; after rsp_ready=1, state returns to IDLE in 1 cycle.
- Miss: key=16'h0000 with CAM valid=0, num_match=0 -> rsp_hit=0, rsp_count=0; with CAM_LOOKUP_ARB_STATS_EN defined, stat_miss increments by 1.
- Reset mid-WAIT: assert reset during WAIT -> next cycle rsp_valid=0, state=INIT, cam_init=2'b11, pointer=0.
